imem_loader: RTL and testbench

Boot-time program loader that sits upstream of the pipelined core. It receives a framed byte stream, assembles 32-bit instruction words, and writes them into program memory at consecutive word addresses. It verifies an XOR checksum and only then releases the core through `o_core_run`, which is tied to the core's active-low reset. It holds the core in reset while loading and on any framing error.

---
 rtl/imem_loader_pkg.sv | 26 ++
 rtl/imem_loader_byte_assembler.sv | 33 +++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package imem_loader_pkg;

    localparam int CNT_W          = 16;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = 2;

    typedef enum logic [2:0] {
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

    function automatic logic [BYTE_W-1:0] csum_update(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] b
    );
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs big-endian stream bytes into 32-bit words; word_done pulses the cycle
// after the fourth byte of a word has been shifted in.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done,
    output logic [IDX_W-1:0]  byte_idx
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            word_done <= 1'b0;
            byte_idx  <= '0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
            end else if (shift_en) begin
                word      <= {word[WORD_W-BYTE_W-1:0], byte_in};
                byte_idx  <= byte_idx + IDX_W'(1);
                word_done <= (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes words to program memory, checks
// the XOR checksum and only then releases the core from reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_run,
    output logic              o_busy,
    output logic              o_error,
    output logic [15:0]       o_words_loaded
);

    loader_state_t     state;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  word_n;
    logic [BYTE_W-1:0] hdr_hi;
    logic [BYTE_W-1:0] csum_acc;
    logic [IDX_W-1:0]  byte_idx;
    logic [CNT_W-1:0]  hdr_n;
    logic              accept;
    logic              restart;
    logic              word_last;
    logic              oversize;

    assign accept    = i_byte_valid && o_byte_ready;
    assign restart   = i_start && (state == ST_DONE || state == ST_ERROR);
    assign word_last = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign hdr_n     = {hdr_hi, i_byte};
    assign oversize  = ({{(32-CNT_W){1'b0}}, hdr_n} > DEPTH);

    assign o_words_loaded = word_cnt;

    byte_assembler u_asm (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clear     (restart),
        .shift_en  (accept && state == ST_DATA),
        .byte_in   (i_byte),
        .word      (o_imem_wdata),
        .word_done (o_imem_we),
        .byte_idx  (byte_idx)
    );

    // Header capture is pure data; it is always rewritten before it is used.
    always_ff @(posedge i_clk) begin
        if (accept && state == ST_HDR_HI) hdr_hi <= i_byte;
        if (accept && state == ST_HDR_LO) word_n <= hdr_n;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_HDR_HI;
            word_cnt     <= '0;
            csum_acc     <= '0;
            o_imem_addr  <= '0;
            o_core_run   <= 1'b0;
            o_error      <= 1'b0;
            o_byte_ready <= 1'b1;
            o_busy       <= 1'b1;
        end else begin
            case (state)
                ST_HDR_HI: begin
                    if (accept) begin
                        csum_acc <= csum_update(csum_acc, i_byte);
                        state    <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        csum_acc <= csum_update(csum_acc, i_byte);
                        if (oversize) begin
                            state        <= ST_ERROR;
                            o_error      <= 1'b1;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                        end else if (hdr_n == '0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum_acc <= csum_update(csum_acc, i_byte);
                        if (word_last) begin
                            // Address is latched alongside the assembler's write pulse.
                            o_imem_addr <= word_cnt[ADDR_W-1:0];
                            word_cnt    <= word_cnt + CNT_W'(1);
                            if (word_cnt + CNT_W'(1) == word_n) state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        o_byte_ready <= 1'b0;
                        o_busy       <= 1'b0;
                        if (i_byte == csum_acc) begin
                            state      <= ST_DONE;
                            o_core_run <= 1'b1;
                        end else begin
                            state   <= ST_ERROR;
                            o_error <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        state        <= ST_HDR_HI;
                        word_cnt     <= '0;
                        csum_acc     <= '0;
                        o_core_run   <= 1'b0;
                        o_error      <= 1'b0;
                        o_byte_ready <= 1'b1;
                        o_busy       <= 1'b1;
                    end
                end
                default: state <= ST_HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with immediate-assertion checks.
module tb_imem_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              i_rst_n;
    logic              i_start;
    logic              i_byte_valid;
    logic [7:0]        i_byte;
    logic              o_byte_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_core_run;
    logic              o_busy;
    logic              o_error;
    logic [15:0]       o_words_loaded;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    logic [7:0]        fa[11];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_byte_valid   (i_byte_valid),
        .i_byte         (i_byte),
        .o_byte_ready   (o_byte_ready),
        .o_imem_we      (o_imem_we),
        .o_imem_addr    (o_imem_addr),
        .o_imem_wdata   (o_imem_wdata),
        .o_core_run     (o_core_run),
        .o_busy         (o_busy),
        .o_error        (o_error),
        .o_words_loaded (o_words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_imem_we) begin
            wa_q.push_back(o_imem_addr);
            wd_q.push_back(o_imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        i_byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic send_frame_a(input int n, input int maxgap, input logic [7:0] last);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = (i == 10) ? last : fa[i];
            send(b, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_ready"}, 32'(o_byte_ready), 32'd1);
        check({p, "_busy"},  32'(o_busy),       32'd1);
        check({p, "_we"},    32'(o_imem_we),    32'd0);
        check({p, "_addr"},  32'(o_imem_addr),  32'd0);
        check({p, "_wdata"}, o_imem_wdata,      32'd0);
        check({p, "_run"},   32'(o_core_run),   32'd0);
        check({p, "_err"},   32'(o_error),      32'd0);
        check({p, "_words"}, 32'(o_words_loaded), 32'd0);
    endtask

    task automatic check_frame_a_writes(input string p);
        logic [31:0] exp_d[2];
        exp_d[0] = 32'h12345678;
        exp_d[1] = 32'h9ABCDEF0;
        check({p, "_nwr"}, 32'(wa_q.size()), 32'd2);
        for (int i = 0; i < 2; i++) begin
            check({p, "_waddr"}, (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hxxxxxxxx, 32'(i));
            check({p, "_wdata"}, (i < wd_q.size()) ? wd_q[i] : 32'hxxxxxxxx, exp_d[i]);
        end
    endtask

    initial begin
        fa[0] = 8'h00; fa[1] = 8'h02; fa[2] = 8'h12; fa[3] = 8'h34;
        fa[4] = 8'h56; fa[5] = 8'h78; fa[6] = 8'h9A; fa[7] = 8'hBC;
        fa[8] = 8'hDE; fa[9] = 8'hF0; fa[10] = 8'h02;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        i_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two-word frame, back-to-back bytes
        clear_writes();
        send_frame_a(10, 0, 8'h02);
        check("a_run_pre_csum", 32'(o_core_run), 32'd0);
        send(8'h02, 0);
        check_frame_a_writes("a");
        check("a_run",   32'(o_core_run),     32'd1);
        check("a_words", 32'(o_words_loaded), 32'd2);
        check("a_ready", 32'(o_byte_ready),   32'd0);
        check("a_busy",  32'(o_busy),         32'd0);
        check("a_err",   32'(o_error),        32'd0);

        // restart and a one-word frame
        pulse_start();
        check("rs_run",   32'(o_core_run),     32'd0);
        check("rs_ready", 32'(o_byte_ready),   32'd1);
        check("rs_words", 32'(o_words_loaded), 32'd0);
        clear_writes();
        send(8'h00, 0); send(8'h01, 0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        send(8'h01, 0);
        check("w1_nwr",   32'(wa_q.size()), 32'd1);
        check("w1_waddr", (wa_q.size() > 0) ? 32'(wa_q[0]) : 32'hxxxxxxxx, 32'd0);
        check("w1_wdata", (wd_q.size() > 0) ? wd_q[0] : 32'hxxxxxxxx, 32'hAABBCCDD);
        check("w1_run",   32'(o_core_run),     32'd1);
        check("w1_words", 32'(o_words_loaded), 32'd1);

        // zero-length frame
        pulse_start();
        clear_writes();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        check("z_nwr",   32'(wa_q.size()),     32'd0);
        check("z_run",   32'(o_core_run),      32'd1);
        check("z_words", 32'(o_words_loaded),  32'd0);

        // bad checksum
        pulse_start();
        clear_writes();
        send_frame_a(11, 0, 8'h03);
        check_frame_a_writes("bc");
        check("bc_err",   32'(o_error),      32'd1);
        check("bc_run",   32'(o_core_run),   32'd0);
        check("bc_ready", 32'(o_byte_ready), 32'd0);

        // oversize header
        pulse_start();
        check("ov_err_cleared", 32'(o_error), 32'd0);
        clear_writes();
        send(8'h04, 0);
        send(8'h01, 0);
        check("ov_err",   32'(o_error),      32'd1);
        check("ov_ready", 32'(o_byte_ready), 32'd0);
        check("ov_busy",  32'(o_busy),       32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ov_nwr", 32'(wa_q.size()), 32'd0);

        // N == DEPTH is accepted, then an asynchronous reset
        pulse_start();
        send(8'h04, 0);
        send(8'h00, 0);
        check("dp_err",   32'(o_error),      32'd0);
        check("dp_ready", 32'(o_byte_ready), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;

        // two-word frame with random valid gaps
        clear_writes();
        send_frame_a(11, 3, 8'h02);
        check_frame_a_writes("gap");
        check("gap_run", 32'(o_core_run), 32'd1);

        // reset after six bytes, then a fresh load
        pulse_start();
        send_frame_a(6, 0, 8'h02);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_reset_vals("mid");
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        clear_writes();
        send_frame_a(11, 0, 8'h02);
        check_frame_a_writes("post");
        check("post_run",   32'(o_core_run),     32'd1);
        check("post_words", 32'(o_words_loaded), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
